dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the number of valid 64-bit data-memory words (addresses 0..MEM_WORDS-1).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum number of consecutive M grants while F waits.
REQ-003 The block SHALL have these ports:
  clk        in   1   sole clock, rising edge
  rst_n      in   1   asynchronous active-low reset
  f_req      in   1   fetch-side read request
  f_addr     in   64  fetch word address
  f_gnt      out  1   fetch completion pulse
  f_rdata    out  64  fetch read data
  f_err      out  1   fetch address error, valid with f_gnt
  m_req      in   1   memory-stage request
  m_we       in   1   1 = write (rmmovq/call/pushq), 0 = read (mrmovq/ret/popq)
  m_addr     in   64  memory-stage word address (valE or valA)
  m_wdata    in   64  write data (valA or valP)
  m_gnt      out  1   memory-stage completion pulse
  m_rdata    out  64  read data (valM)
  m_err      out  1   memory-stage address error, valid with m_gnt
  mem_req    out  1   single-port RAM request
  mem_we     out  1   RAM write enable
  mem_addr   out  64  RAM address
  mem_wdata  out  64  RAM write data
  mem_ack    in   1   RAM completion, 1 cycle
  mem_rdata  in   64  RAM read data, valid with mem_ack

Function
REQ-004 The controller SHALL be a state machine with states IDLE, ISSUE_F, ISSUE_M and DONE.
REQ-005 Each requester SHALL hold its req and its addr/we/wdata stable until it samples its gnt, and SHALL drop req in the following cycle.
REQ-006 In IDLE, if exactly one req is high, that requester SHALL be selected.
REQ-007 In IDLE, if both reqs are high, M SHALL be selected unless starve_cnt == STARVE_LIMIT, in which case F SHALL be selected.
REQ-008 starve_cnt (3 bits) SHALL increment on each M selection made while f_req is high.
REQ-009 starve_cnt SHALL clear on any F selection and in any IDLE cycle with f_req low.
REQ-010 starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-011 If the selected address is >= MEM_WORDS, the next state SHALL be DONE with the matching err set, and no mem_req SHALL be issued.
REQ-012 Otherwise, the next state SHALL be ISSUE_F or ISSUE_M.
REQ-013 In ISSUE_x, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from the registered request.
REQ-014 F requests SHALL always drive mem_we = 0.
REQ-015 ISSUE_x SHALL be held until mem_ack, then transition to DONE.
REQ-016 On a read, mem_rdata SHALL be captured into the matching rdata on the mem_ack edge.
REQ-017 Writes SHALL leave m_rdata unchanged.
REQ-018 DONE SHALL last exactly 1 cycle, pulse the matching gnt for that cycle, and then go to IDLE.
REQ-019 No arbitration SHALL occur in DONE.
REQ-020 Minimum latency SHALL be: req sampled at edge N, mem_req high in cycle N+1, mem_ack in N+1, gnt high in cycle N+2.
REQ-021 mem_ack outside ISSUE_x SHALL be ignored.
REQ-022 mem_req SHALL never assert in IDLE or DONE.
REQ-023 f_gnt and m_gnt SHALL never be high in the same cycle.
REQ-024 err SHALL be 0 whenever the matching gnt is 0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, starve_cnt 0, all gnt/err/mem_req/mem_we 0, and mem_addr, mem_wdata, f_rdata and m_rdata to 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction without a gnt pulse.
REQ-027 After rst_n rises, arbitration SHALL resume on the first clk edge.

Verification
REQ-028 M read only: m_req=1, m_we=0, m_addr=5; RAM acks immediately with 0xDEAD -> mem_req high 1 cycle; m_gnt pulses 2 cycles after req sampled; m_rdata=0xDEAD; m_err=0.
REQ-029 Simultaneous requests: f_addr=1, m_addr=2, m_we=1, m_wdata=7 -> M is served first (mem_we=1, mem_wdata=7); F is served next; exactly one gnt per request.
REQ-030 Starvation: f_req held high while M issues back-to-back requests -> F is selected after exactly 4 M grants.
REQ-031 Address bound: m_addr=1024 -> m_gnt=1 and m_err=1 in the cycle after selection; mem_req stays 0 throughout.
REQ-032 RAM stall plus reset: mem_ack held 0 for 3 cycles, then rst_n pulsed low -> mem_req drops asynchronously; no gnt; after release, a fresh f_req completes normally.
REQ-033 Spurious ack: mem_ack=1 while in IDLE -> no state change and no rdata update.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fetch/memory-stage arbiter for a single-port data RAM, M-priority with an F starvation cap.
module dmem_arbiter #(
  parameter int MEM_WORDS    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_gnt,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_gnt,
  output logic [63:0] m_rdata,
  output logic        m_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE_F, ISSUE_M, DONE} state_t;
  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);
  state_t      r_state, w_next;
  logic [2:0]  r_cnt, w_cnt;
  logic        r_sel_m, r_we, r_err;
  logic [63:0] r_addr, r_wdata, r_frd, r_mrd;
  logic        w_pick_m, w_bad, w_any, w_issue;
  logic [63:0] w_addr;
  assign w_any    = f_req || m_req;
  assign w_issue  = r_state == ISSUE_F || r_state == ISSUE_M;
  assign w_pick_m = m_req && !(f_req && r_cnt == LIM);
  assign w_addr   = w_pick_m ? m_addr : f_addr;
  assign w_bad    = w_addr >= 64'(MEM_WORDS);
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt  = (f_req && w_pick_m) ? ((r_cnt == LIM) ? LIM : r_cnt + 3'd1) : 3'd0;
        w_next = !w_any ? IDLE : w_bad ? DONE : w_pick_m ? ISSUE_M : ISSUE_F;
      end
      ISSUE_F, ISSUE_M: w_next = mem_ack ? DONE : r_state;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel_m <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_frd   <= '0;
      r_mrd   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (r_state == IDLE && w_any) begin
        r_sel_m <= w_pick_m;
        r_we    <= w_pick_m && m_we;
        r_err   <= w_bad;
        r_addr  <= w_addr;
        r_wdata <= m_wdata;
      end
      // read data lands on the ack edge; writes leave both rdata registers alone
      if (w_issue && mem_ack && !r_we) begin
        if (r_sel_m) r_mrd <= mem_rdata;
        else r_frd <= mem_rdata;
      end
    end
  end
  assign mem_req   = w_issue;
  assign mem_we    = r_state == ISSUE_M && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign f_gnt     = r_state == DONE && !r_sel_m;
  assign m_gnt     = r_state == DONE && r_sel_m;
  assign f_err     = f_gnt && r_err;
  assign m_err     = m_gnt && r_err;
  assign f_rdata   = r_frd;
  assign m_rdata   = r_mrd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;
  localparam int MW = 1024;
  localparam int SL = 4;
  logic clk = 0, rst_n = 1, f_req = 0, m_req = 0, m_we = 0, mem_ack = 0, stall = 0, spur = 0;
  logic [63:0] f_addr = 0, m_addr = 0, m_wdata = 0, mem_rdata = 0;
  logic f_gnt, f_err, m_gnt, m_err, mem_req, mem_we;
  logic [63:0] f_rdata, m_rdata, mem_addr, mem_wdata;
  logic [63:0] ram [0:MW-1];
  int errors = 0, checks = 0, fg_cnt = 0, mg_cnt = 0, mreq_cnt = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rdata(m_rdata), .m_err(m_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction; grant one cycle after ack (or after selection for a bad address)
  logic busy, due, t_m, t_we, t_bad, pick_m;
  logic [63:0] t_addr, t_wd, e_frd, e_mrd, sel_addr;
  int streak;
  assign pick_m   = m_req && !(f_req && streak >= SL);
  assign sel_addr = pick_m ? m_addr : f_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 0; due <= 0; t_m <= 0; t_we <= 0; t_bad <= 0;
      t_addr <= 0; t_wd <= 0; e_frd <= 0; e_mrd <= 0; streak <= 0;
    end else if (due) due <= 0;
    else if (busy) begin
      if (mem_ack) begin
        busy <= 0;
        due  <= 1;
        if (!t_m) e_frd <= mem_rdata;
        else if (!t_we) e_mrd <= mem_rdata;
      end
    end else if (f_req || m_req) begin
      t_m    <= pick_m;
      t_we   <= pick_m && m_we;
      t_addr <= sel_addr;
      t_wd   <= m_wdata;
      t_bad  <= sel_addr >= 64'(MW);
      streak <= (f_req && pick_m) ? ((streak < SL) ? streak + 1 : streak) : 0;
      if (sel_addr >= 64'(MW)) due <= 1;
      else busy <= 1;
    end else streak <= 0;
  end

  initial forever begin
    @(negedge clk);
    if (f_gnt) fg_cnt++;
    if (m_gnt) mg_cnt++;
    if (mem_req) mreq_cnt++;
    chk("mem_req", 64'(mem_req), 64'(busy));
    chk("mem_we", 64'(mem_we), 64'(busy && t_m && t_we));
    chk("f_gnt", 64'(f_gnt), 64'(due && !t_m));
    chk("m_gnt", 64'(m_gnt), 64'(due && t_m));
    chk("f_err", 64'(f_err), 64'(due && !t_m && t_bad));
    chk("m_err", 64'(m_err), 64'(due && t_m && t_bad));
    chk("f_rdata", f_rdata, e_frd);
    chk("m_rdata", m_rdata, e_mrd);
    if (busy) chk("mem_addr", mem_addr, t_addr);
    if (busy && t_we) chk("mem_wdata", mem_wdata, t_wd);
  end

  // RAM: acks in the first issue cycle unless stalled; spur injects an ack with no request
  initial forever begin
    @(posedge clk);
    #1;
    mem_ack   = spur || (mem_req && !stall);
    mem_rdata = spur ? 64'hBAD0 : ram[mem_addr[9:0]];
    if (mem_ack && mem_req && mem_we) ram[mem_addr[9:0]] = mem_wdata;
  end

  task automatic f_txn(input logic [63:0] a, output int lat, output logic err);
    @(posedge clk); #2;
    f_req = 1; f_addr = a; lat = 0;
    do begin @(negedge clk); lat++; end while (!f_gnt && lat < 60);
    err = f_err;
    chk("f_gnt_seen", 64'(f_gnt), 64'd1);
    @(posedge clk); #2;
    f_req = 0;
  endtask

  task automatic m_txn(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic drop,
                       output int lat, output logic err);
    @(posedge clk); #2;
    m_req = 1; m_we = we; m_addr = a; m_wdata = wd; lat = 0;
    do begin @(negedge clk); lat++; end while (!m_gnt && lat < 60);
    err = m_err;
    chk("m_gnt_seen", 64'(m_gnt), 64'd1);
    if (drop) begin @(posedge clk); #2; m_req = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lf, lm, c0, g0, h0, mg_at_f;
    logic ef, em;
    for (int i = 0; i < MW; i++) ram[i] = 64'h1000 + 64'(i);
    ram[5] = 64'hDEAD;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_m_rdata", m_rdata, 64'd0);
    chk("rst_f_gnt", 64'(f_gnt), 64'd0);
    rst_n = 1;
    c0 = mreq_cnt;
    m_txn(0, 5, 0, 1, lm, em);
    chk("rd_lat", 64'(lm), 64'd3);
    chk("rd_err", 64'(em), 64'd0);
    chk("rd_data", m_rdata, 64'hDEAD);
    chk("rd_mreq_cycles", 64'(mreq_cnt - c0), 64'd1);
    g0 = fg_cnt; h0 = mg_cnt;
    @(posedge clk); #2 spur = 1;
    repeat (3) @(posedge clk);
    #2 spur = 0;
    repeat (2) @(negedge clk);
    chk("spur_m_rdata", m_rdata, 64'hDEAD);
    chk("spur_f_rdata", f_rdata, 64'd0);
    chk("spur_gnts", 64'((fg_cnt - g0) + (mg_cnt - h0)), 64'd0);
    g0 = fg_cnt; h0 = mg_cnt;
    fork
      f_txn(1, lf, ef);
      m_txn(1, 2, 7, 1, lm, em);
    join
    chk("both_m_lat", 64'(lm), 64'd3);
    chk("both_f_lat", 64'(lf), 64'd6);
    chk("both_ram_wr", ram[2], 64'd7);
    chk("both_f_data", f_rdata, 64'h1001);
    chk("wr_keeps_m_rdata", m_rdata, 64'hDEAD);
    chk("both_f_once", 64'(fg_cnt - g0), 64'd1);
    chk("both_m_once", 64'(mg_cnt - h0), 64'd1);
    m_txn(0, 2, 0, 1, lm, em);
    chk("rd_after_wr", m_rdata, 64'd7);
    h0 = mg_cnt;
    fork
      begin f_txn(3, lf, ef); mg_at_f = mg_cnt - h0; end
      begin for (int i = 0; i < 6; i++) m_txn(0, 64'(10 + i), 0, i == 5, lm, em); end
    join
    chk("starve_m_before_f", 64'(mg_at_f), 64'd4);
    chk("starve_f_lat", 64'(lf), 64'd15);
    chk("starve_f_data", f_rdata, 64'h1003);
    chk("starve_m_last", m_rdata, 64'h100F);
    c0 = mreq_cnt;
    m_txn(0, 1024, 0, 1, lm, em);
    chk("oob_m_lat", 64'(lm), 64'd2);
    chk("oob_m_err", 64'(em), 64'd1);
    chk("oob_no_mreq", 64'(mreq_cnt - c0), 64'd0);
    chk("oob_m_rdata_kept", m_rdata, 64'h100F);
    f_txn(1023, lf, ef);
    chk("top_f_err", 64'(ef), 64'd0);
    chk("top_f_data", f_rdata, 64'h13FF);
    f_txn(64'h8000_0000_0000_0000, lf, ef);
    chk("oob_f_lat", 64'(lf), 64'd2);
    chk("oob_f_err", 64'(ef), 64'd1);
    stall = 1;
    g0 = fg_cnt;
    @(posedge clk); #2;
    f_req = 1; f_addr = 9;
    repeat (4) @(negedge clk);
    chk("stall_mem_req", 64'(mem_req), 64'd1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_async_mem_req", 64'(mem_req), 64'd0);
    chk("rst_f_rdata", f_rdata, 64'd0);
    f_req = 0; stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_no_gnt", 64'(fg_cnt - g0), 64'd0);
    f_txn(9, lf, ef);
    chk("post_rst_lat", 64'(lf), 64'd3);
    chk("post_rst_data", f_rdata, 64'h1009);
    chk("post_rst_err", 64'(ef), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
